// File: rtl/mips_cycle_sequencer.sv
// Multi-cycle MIPS control sequencer: fetch/decode/exec/mem/wb over a stalling single-port bus.
// Optional SEQ_MULDIV_EN adds a MULDIV wait state with muldiv_start/muldiv_done handshake.
module mips_cycle_sequencer #(
  parameter int unsigned WAIT_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       waitrequest,
  input  logic       pc_next_zero,
`ifdef SEQ_MULDIV_EN
  input  logic       muldiv_done,
  output logic       muldiv_start,
`endif
  output logic       mem_read,
  output logic       mem_write,
  output logic       addr_sel,
  output logic       ir_write,
  output logic       reg_write,
  output logic       pc_write,
  output logic       active,
  output logic       timeout_err,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6,
    S_MULDIV = 3'd7
  } st_t;

  st_t cur_st, nxt_st;

  // Instruction class, combinational from IR fields
  logic op_load, op_store, op_nowb, op_md;

  always_comb begin
    op_load  = opcode inside {[6'h20:6'h26]};
    op_store = opcode inside {6'h28, 6'h29, 6'h2B};
    op_md    = (opcode == 6'h00) && (funct inside {[6'h18:6'h1B]});
    op_nowb  = (opcode inside {6'h01, 6'h02, [6'h04:6'h07]}) ||
               ((opcode == 6'h00) && (funct == 6'h08));
`ifndef SEQ_MULDIV_EN
    op_nowb  = op_nowb || op_md;
`endif
  end

  // Class is captured in DECODE so EXEC/MEM do not depend on IR timing
  logic cls_load, cls_store, cls_nowb;
`ifdef SEQ_MULDIV_EN
  logic cls_md;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cls_load  <= 1'b0;
      cls_store <= 1'b0;
      cls_nowb  <= 1'b0;
`ifdef SEQ_MULDIV_EN
      cls_md    <= 1'b0;
`endif
    end else if (cur_st == S_DECODE) begin
      cls_load  <= op_load;
      cls_store <= op_store;
      cls_nowb  <= op_nowb;
`ifdef SEQ_MULDIV_EN
      cls_md    <= op_md;
`endif
    end
  end

  // Watchdog over consecutive bus stall cycles
  logic [7:0] wd_cnt;
  logic       bus_st, stall, wd_fire;
  localparam logic [8:0] WD_LIM = 9'(WAIT_TIMEOUT);

  assign bus_st  = (cur_st == S_FETCH) || (cur_st == S_MEM);
  assign stall   = bus_st && waitrequest;
  assign wd_fire = (WAIT_TIMEOUT != 0) && stall && (({1'b0, wd_cnt} + 9'd1) >= WD_LIM);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wd_cnt <= 8'd0;
    end else if (stall) begin
      if (wd_cnt != 8'hFF) wd_cnt <= wd_cnt + 8'd1;
    end else if (bus_st) begin
      wd_cnt <= 8'd0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)     timeout_err <= 1'b0;
    else if (wd_fire) timeout_err <= 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cur_st <= S_IDLE;
    else          cur_st <= nxt_st;
  end

  always_comb begin
    nxt_st    = cur_st;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    addr_sel  = 1'b0;
    ir_write  = 1'b0;
    reg_write = 1'b0;
    pc_write  = 1'b0;
`ifdef SEQ_MULDIV_EN
    muldiv_start = 1'b0;
`endif
    unique case (cur_st)
      S_IDLE:   nxt_st = S_FETCH;
      S_FETCH: begin
        mem_read = 1'b1;
        if (!waitrequest) begin
          ir_write = 1'b1;
          nxt_st   = S_DECODE;
        end
      end
      S_DECODE: nxt_st = S_EXEC;
      S_EXEC: begin
        if (cls_load || cls_store) begin
          nxt_st = S_MEM;
`ifdef SEQ_MULDIV_EN
        end else if (cls_md) begin
          muldiv_start = 1'b1;
          nxt_st       = S_MULDIV;
`endif
        end else if (cls_nowb) begin
          pc_write = 1'b1;
          nxt_st   = S_FETCH;
        end else begin
          nxt_st = S_WB;
        end
      end
      S_MEM: begin
        addr_sel  = 1'b1;
        mem_read  = cls_load;
        mem_write = cls_store && !cls_load;
        if (!waitrequest) begin
          if (cls_store && !cls_load) begin
            pc_write = 1'b1;
            nxt_st   = S_FETCH;
          end else begin
            nxt_st = S_WB;
          end
        end
      end
      S_WB: begin
        reg_write = 1'b1;
        pc_write  = 1'b1;
        nxt_st    = S_FETCH;
      end
      S_HALT:   nxt_st = S_HALT;
`ifdef SEQ_MULDIV_EN
      S_MULDIV: begin
        if (muldiv_done) begin
          pc_write = 1'b1;
          nxt_st   = S_FETCH;
        end
      end
`endif
      default:  nxt_st = S_HALT;
    endcase
    // A commit to PC 0 or a watchdog expiry overrides the normal successor
    if (pc_write && pc_next_zero) nxt_st = S_HALT;
    if (wd_fire)                  nxt_st = S_HALT;
  end

  assign active = (cur_st != S_IDLE) && (cur_st != S_HALT);
  assign state  = cur_st;

  a_bus_mutex: assert property (@(posedge clk) disable iff (!reset_n) !(mem_read && mem_write));
  a_ir_pulse:  assert property (@(posedge clk) disable iff (!reset_n) ir_write  |=> !ir_write);
  a_rw_pulse:  assert property (@(posedge clk) disable iff (!reset_n) reg_write |=> !reg_write);
  a_pc_pulse:  assert property (@(posedge clk) disable iff (!reset_n) pc_write  |=> !pc_write);

endmodule

// File: tb/tb_mips_cycle_sequencer.sv
// Scoreboard bench for mips_cycle_sequencer: per-cycle expected output vectors queued with stimulus.
module tb_mips_cycle_sequencer;

  localparam logic [2:0] S_I = 3'd0, S_F = 3'd1, S_D = 3'd2, S_E = 3'd3,
                         S_M = 3'd4, S_W = 3'd5, S_H = 3'd6, S_X = 3'd7;
  localparam logic [7:0] MR = 8'h80, MW = 8'h40, AS = 8'h20, IRW = 8'h10,
                         RW = 8'h08, PCW = 8'h04, ACT = 8'h02, TO = 8'h01;
  localparam int C_WB = 0, C_NOWB = 1, C_LOAD = 2, C_STORE = 3, C_MD = 4;

  logic       clk, reset_n, reset4_n;
  logic [5:0] opcode, funct;
  logic       waitrequest, pc_next_zero;
  logic       mem_read, mem_write, addr_sel, ir_write, reg_write, pc_write, active, timeout_err;
  logic [2:0] state;
  logic       mem_read4, mem_write4, addr_sel4, ir_write4, reg_write4, pc_write4, active4, timeout_err4;
  logic [2:0] state4;
  logic [10:0] obs, obs4;

  int checks = 0;
  int errors = 0;
  logic [13:0] stim_q[$];
  logic [10:0] exp_q[$];

`ifdef SEQ_MULDIV_EN
  logic muldiv_start, muldiv_start4;
  logic muldiv_done = 1'b1;
`endif

  mips_cycle_sequencer dut (
    .clk(clk), .reset_n(reset_n), .opcode(opcode), .funct(funct),
    .waitrequest(waitrequest), .pc_next_zero(pc_next_zero),
`ifdef SEQ_MULDIV_EN
    .muldiv_done(muldiv_done), .muldiv_start(muldiv_start),
`endif
    .mem_read(mem_read), .mem_write(mem_write), .addr_sel(addr_sel), .ir_write(ir_write),
    .reg_write(reg_write), .pc_write(pc_write), .active(active), .timeout_err(timeout_err),
    .state(state)
  );

  mips_cycle_sequencer #(.WAIT_TIMEOUT(4)) dut4 (
    .clk(clk), .reset_n(reset4_n), .opcode(opcode), .funct(funct),
    .waitrequest(waitrequest), .pc_next_zero(pc_next_zero),
`ifdef SEQ_MULDIV_EN
    .muldiv_done(muldiv_done), .muldiv_start(muldiv_start4),
`endif
    .mem_read(mem_read4), .mem_write(mem_write4), .addr_sel(addr_sel4), .ir_write(ir_write4),
    .reg_write(reg_write4), .pc_write(pc_write4), .active(active4), .timeout_err(timeout_err4),
    .state(state4)
  );

  assign obs  = {state, mem_read, mem_write, addr_sel, ir_write, reg_write, pc_write, active, timeout_err};
  assign obs4 = {state4, mem_read4, mem_write4, addr_sel4, ir_write4, reg_write4, pc_write4, active4,
                 timeout_err4};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [10:0] ev(input logic [2:0] s, input logic [7:0] f);
    return {s, f};
  endfunction

  function automatic int cls_of(input logic [5:0] op, input logic [5:0] fn);
    if (op inside {[6'h20:6'h26]}) return C_LOAD;
    if (op inside {6'h28, 6'h29, 6'h2B}) return C_STORE;
`ifdef SEQ_MULDIV_EN
    if (op == 6'h00 && fn inside {[6'h18:6'h1B]}) return C_MD;
`else
    if (op == 6'h00 && fn inside {[6'h18:6'h1B]}) return C_NOWB;
`endif
    if (op inside {6'h01, 6'h02, [6'h04:6'h07]} || (op == 6'h00 && fn == 6'h08)) return C_NOWB;
    return C_WB;
  endfunction

  task automatic push(input logic [5:0] op, input logic [5:0] fn, input logic wr, input logic pz,
                      input logic [10:0] e);
    stim_q.push_back({op, fn, wr, pz});
    exp_q.push_back(e);
  endtask

  // Stall-free instruction expectation built from the opcode class table
  task automatic push_instr(input logic [5:0] op, input logic [5:0] fn);
    int c;
    c = cls_of(op, fn);
    push(op, fn, 1'b0, 1'b0, ev(S_F, MR | IRW | ACT));
    push(op, fn, 1'b0, 1'b0, ev(S_D, ACT));
    case (c)
      C_NOWB:  push(op, fn, 1'b0, 1'b0, ev(S_E, PCW | ACT));
      C_LOAD: begin
        push(op, fn, 1'b0, 1'b0, ev(S_E, ACT));
        push(op, fn, 1'b0, 1'b0, ev(S_M, MR | AS | ACT));
        push(op, fn, 1'b0, 1'b0, ev(S_W, RW | PCW | ACT));
      end
      C_STORE: begin
        push(op, fn, 1'b0, 1'b0, ev(S_E, ACT));
        push(op, fn, 1'b0, 1'b0, ev(S_M, MW | AS | PCW | ACT));
      end
      C_MD: begin
        push(op, fn, 1'b0, 1'b0, ev(S_E, ACT));
        push(op, fn, 1'b0, 1'b0, ev(S_X, PCW | ACT));
      end
      default: begin
        push(op, fn, 1'b0, 1'b0, ev(S_E, ACT));
        push(op, fn, 1'b0, 1'b0, ev(S_W, RW | PCW | ACT));
      end
    endcase
  endtask

  // Leaves the selected instance in IDLE at posedge+1, the other held in reset
  task automatic do_reset(input bit use4);
    reset_n = 1'b0; reset4_n = 1'b0;
    waitrequest = 1'b0; pc_next_zero = 1'b0;
    @(posedge clk); #1;
    if (use4) reset4_n = 1'b1;
    else      reset_n  = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; reset4_n = 1'b0;
    opcode = 6'h0; funct = 6'h0; waitrequest = 1'b0; pc_next_zero = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (obs !== 11'd0) begin errors++; $display("FAIL reset_main got %b want %b", obs, 11'd0); end
    checks++;
    if (obs4 !== 11'd0) begin errors++; $display("FAIL reset_wd4 got %b want %b", obs4, 11'd0); end
  endtask

  task automatic test_reset_mid_mem();
    logic [13:0] s; logic [10:0] e; int cyc = 0;
    do_reset(1'b0);
    push(6'h2B, 6'h0, 1'b0, 1'b0, ev(S_I, 8'h0));
    push(6'h2B, 6'h0, 1'b0, 1'b0, ev(S_F, MR | IRW | ACT));
    push(6'h2B, 6'h0, 1'b0, 1'b0, ev(S_D, ACT));
    push(6'h2B, 6'h0, 1'b0, 1'b0, ev(S_E, ACT));
    push(6'h2B, 6'h0, 1'b1, 1'b0, ev(S_M, MW | AS | ACT));
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      {opcode, funct, waitrequest, pc_next_zero} = s;
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin errors++; $display("FAIL mid_mem cyc %0d got %b want %b", cyc, obs, e); end
      cyc++;
      @(posedge clk); #1;
    end
    checks++;
    if (obs !== ev(S_M, MW | AS | ACT))
      begin errors++; $display("FAIL mid_mem_hold got %b want %b", obs, ev(S_M, MW | AS | ACT)); end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (obs !== 11'd0) begin errors++; $display("FAIL mid_mem_async got %b want %b", obs, 11'd0); end
  endtask

  task automatic test_addu();
    logic [13:0] s; logic [10:0] e; int cyc = 0;
    do_reset(1'b0);
    push(6'h00, 6'h21, 1'b0, 1'b0, ev(S_I, 8'h0));
    push_instr(6'h00, 6'h21);
    push(6'h00, 6'h21, 1'b0, 1'b0, ev(S_F, MR | IRW | ACT));
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      {opcode, funct, waitrequest, pc_next_zero} = s;
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin errors++; $display("FAIL addu cyc %0d got %b want %b", cyc, obs, e); end
      cyc++;
      @(posedge clk); #1;
    end
  endtask

  // 3 fetch stalls + 2 mem stalls put the WB cycle at index 10 (IDLE is index 0)
  task automatic test_lw_stall();
    logic [13:0] s; logic [10:0] e; int cyc = 0;
    do_reset(1'b0);
    push(6'h23, 6'h0, 1'b0, 1'b0, ev(S_I, 8'h0));
    repeat (3) push(6'h23, 6'h0, 1'b1, 1'b0, ev(S_F, MR | ACT));
    push(6'h23, 6'h0, 1'b0, 1'b0, ev(S_F, MR | IRW | ACT));
    push(6'h23, 6'h0, 1'b1, 1'b0, ev(S_D, ACT));
    push(6'h23, 6'h0, 1'b1, 1'b0, ev(S_E, ACT));
    repeat (2) push(6'h23, 6'h0, 1'b1, 1'b0, ev(S_M, MR | AS | ACT));
    push(6'h23, 6'h0, 1'b0, 1'b0, ev(S_M, MR | AS | ACT));
    push(6'h23, 6'h0, 1'b1, 1'b0, ev(S_W, RW | PCW | ACT));
    push(6'h23, 6'h0, 1'b1, 1'b0, ev(S_F, MR | ACT));
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      {opcode, funct, waitrequest, pc_next_zero} = s;
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin errors++; $display("FAIL lw_stall cyc %0d got %b want %b", cyc, obs, e); end
      cyc++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_sw();
    logic [13:0] s; logic [10:0] e; int cyc = 0;
    do_reset(1'b0);
    push(6'h2B, 6'h0, 1'b0, 1'b0, ev(S_I, 8'h0));
    push(6'h2B, 6'h0, 1'b0, 1'b0, ev(S_F, MR | IRW | ACT));
    push(6'h2B, 6'h0, 1'b0, 1'b0, ev(S_D, ACT));
    push(6'h2B, 6'h0, 1'b0, 1'b0, ev(S_E, ACT));
    push(6'h2B, 6'h0, 1'b1, 1'b0, ev(S_M, MW | AS | ACT));
    push(6'h2B, 6'h0, 1'b0, 1'b0, ev(S_M, MW | AS | PCW | ACT));
    push(6'h2B, 6'h0, 1'b0, 1'b0, ev(S_F, MR | IRW | ACT));
    push(6'h2B, 6'h0, 1'b0, 1'b0, ev(S_D, ACT));
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      {opcode, funct, waitrequest, pc_next_zero} = s;
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin errors++; $display("FAIL sw cyc %0d got %b want %b", cyc, obs, e); end
      cyc++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_jr_halt();
    logic [13:0] s; logic [10:0] e; int cyc = 0;
    do_reset(1'b0);
    push(6'h00, 6'h08, 1'b0, 1'b1, ev(S_I, 8'h0));
    push(6'h00, 6'h08, 1'b0, 1'b1, ev(S_F, MR | IRW | ACT));
    push(6'h00, 6'h08, 1'b0, 1'b1, ev(S_D, ACT));
    push(6'h00, 6'h08, 1'b0, 1'b1, ev(S_E, PCW | ACT));
    for (int i = 0; i < 6; i++) push(6'h23, 6'h08, i[0], 1'b1, ev(S_H, 8'h0));
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      {opcode, funct, waitrequest, pc_next_zero} = s;
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin errors++; $display("FAIL jr_halt cyc %0d got %b want %b", cyc, obs, e); end
      cyc++;
      @(posedge clk); #1;
    end
  endtask

  // Load with pc_next_zero high throughout: only the WB commit may halt it
  task automatic test_commit_halt();
    logic [13:0] s; logic [10:0] e; int cyc = 0;
    do_reset(1'b0);
    push(6'h20, 6'h0, 1'b0, 1'b1, ev(S_I, 8'h0));
    push(6'h20, 6'h0, 1'b0, 1'b1, ev(S_F, MR | IRW | ACT));
    push(6'h20, 6'h0, 1'b0, 1'b1, ev(S_D, ACT));
    push(6'h20, 6'h0, 1'b0, 1'b1, ev(S_E, ACT));
    push(6'h20, 6'h0, 1'b0, 1'b1, ev(S_M, MR | AS | ACT));
    push(6'h20, 6'h0, 1'b0, 1'b1, ev(S_W, RW | PCW | ACT));
    push(6'h20, 6'h0, 1'b0, 1'b0, ev(S_H, 8'h0));
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      {opcode, funct, waitrequest, pc_next_zero} = s;
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin errors++; $display("FAIL commit_halt cyc %0d got %b want %b", cyc, obs, e); end
      cyc++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    logic [13:0] s; logic [10:0] e; int cyc = 0;
    logic [11:0] prog [16];
    prog = '{ {6'h04, 6'h00}, {6'h02, 6'h00}, {6'h09, 6'h00}, {6'h0F, 6'h00},
              {6'h03, 6'h00}, {6'h28, 6'h00}, {6'h20, 6'h00}, {6'h25, 6'h00},
              {6'h00, 6'h09}, {6'h00, 6'h18}, {6'h3F, 6'h00}, {6'h01, 6'h00},
              {6'h07, 6'h00}, {6'h29, 6'h00}, {6'h26, 6'h00}, {6'h00, 6'h1B} };
    do_reset(1'b0);
    push(6'h00, 6'h00, 1'b0, 1'b0, ev(S_I, 8'h0));
    for (int i = 0; i < 16; i++) push_instr(prog[i][11:6], prog[i][5:0]);
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      {opcode, funct, waitrequest, pc_next_zero} = s;
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin errors++; $display("FAIL b2b cyc %0d got %b want %b", cyc, obs, e); end
      cyc++;
      @(posedge clk); #1;
    end
  endtask

  // Default watchdog (255) must tolerate a long stall
  task automatic test_long_stall();
    logic [13:0] s; logic [10:0] e; int cyc = 0;
    do_reset(1'b0);
    push(6'h00, 6'h21, 1'b0, 1'b0, ev(S_I, 8'h0));
    repeat (40) push(6'h00, 6'h21, 1'b1, 1'b0, ev(S_F, MR | ACT));
    push_instr(6'h00, 6'h21);
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      {opcode, funct, waitrequest, pc_next_zero} = s;
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin errors++; $display("FAIL long_stall cyc %0d got %b want %b", cyc, obs, e); end
      cyc++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_watchdog();
    logic [13:0] s; logic [10:0] e; int cyc = 0;
    do_reset(1'b1);
    push(6'h00, 6'h21, 1'b0, 1'b0, ev(S_I, 8'h0));
    repeat (3) push(6'h00, 6'h21, 1'b1, 1'b0, ev(S_F, MR | ACT));
    push(6'h00, 6'h21, 1'b0, 1'b0, ev(S_F, MR | IRW | ACT));
    push(6'h00, 6'h21, 1'b0, 1'b0, ev(S_D, ACT));
    push(6'h00, 6'h21, 1'b0, 1'b0, ev(S_E, ACT));
    push(6'h00, 6'h21, 1'b0, 1'b0, ev(S_W, RW | PCW | ACT));
    repeat (4) push(6'h00, 6'h21, 1'b1, 1'b0, ev(S_F, MR | ACT));
    for (int i = 0; i < 5; i++) push(6'h00, 6'h21, i[0], 1'b0, ev(S_H, TO));
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      {opcode, funct, waitrequest, pc_next_zero} = s;
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (obs4 !== e) begin errors++; $display("FAIL watchdog cyc %0d got %b want %b", cyc, obs4, e); end
      cyc++;
      @(posedge clk); #1;
    end
    reset4_n = 1'b0;
    #1;
    checks++;
    if (obs4 !== 11'd0) begin errors++; $display("FAIL watchdog_clear got %b want %b", obs4, 11'd0); end
  endtask

  initial begin
    test_reset();
    test_reset_mid_mem();
    test_addu();
    test_lw_stall();
    test_sw();
    test_jr_halt();
    test_commit_halt();
    test_back_to_back();
    test_long_stall();
    test_watchdog();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
